// File: rtl/rr_arb4_defs_pkg.sv
// Shared constants and index helper for the four-way round-robin arbitration stage.
package rr_arb4_defs;

  localparam int RR_N      = 4;
  localparam int RR_IDX_W  = 2;
  localparam int RR_DATA_W = 32;

  function automatic logic [RR_IDX_W-1:0] rr_next_idx(input logic [RR_IDX_W-1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arb4_stage_mux.sv
// Shared 4:1 word mux feeding the arbitration stage's output register.
module Mux4to1_32b
  import rr_arb4_defs::*;
(
  input  logic [RR_IDX_W-1:0]  S,
  input  logic [RR_DATA_W-1:0] I0,
  input  logic [RR_DATA_W-1:0] I1,
  input  logic [RR_DATA_W-1:0] I2,
  input  logic [RR_DATA_W-1:0] I3,
  output logic [RR_DATA_W-1:0] Y
);

  always_comb begin
    unique case (S)
      2'd0:    Y = I0;
      2'd1:    Y = I1;
      2'd2:    Y = I2;
      default: Y = I3;
    endcase
  end

endmodule

// File: rtl/rr_arb4_stage.sv
// Four-requester round-robin arbiter with a registered single-entry valid/ready output.
// Optional ownership locking is enabled by defining RR_ARB4_LOCK_EN.
module rr_arb4_stage
  import rr_arb4_defs::*;
#(
  parameter logic [RR_IDX_W-1:0] PTR_RESET = 2'd0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RR_N-1:0]      req_valid,
`ifdef RR_ARB4_LOCK_EN
  input  logic [RR_N-1:0]      req_lock,
`endif
  output logic [RR_N-1:0]      req_ready,
  input  logic [RR_DATA_W-1:0] req_data0,
  input  logic [RR_DATA_W-1:0] req_data1,
  input  logic [RR_DATA_W-1:0] req_data2,
  input  logic [RR_DATA_W-1:0] req_data3,
  output logic [RR_IDX_W-1:0]  mux_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RR_DATA_W-1:0] out_data,
  output logic [RR_IDX_W-1:0]  out_src
);

  logic [RR_IDX_W-1:0]  ptr;
  logic [RR_IDX_W-1:0]  gnt;
  logic [RR_IDX_W-1:0]  gnt_dflt;
  logic [RR_IDX_W-1:0]  idx;
  logic [RR_N-1:0]      elig;
  logic                 found;
  logic                 any_elig;
  logic                 can_accept;
  logic                 xfer;
  logic [RR_DATA_W-1:0] mux_y;

`ifdef RR_ARB4_LOCK_EN
  logic                 lock_act;
  logic [RR_IDX_W-1:0]  lock_own;
`endif

  // While a lock is held only the owner may win; otherwise search from ptr.
  always_comb begin
    elig     = req_valid;
    gnt_dflt = ptr;
`ifdef RR_ARB4_LOCK_EN
    if (lock_act) begin
      elig     = req_valid & (4'b0001 << lock_own);
      gnt_dflt = lock_own;
    end
`endif
    gnt   = gnt_dflt;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < RR_N; k++) begin
      idx = ptr + k[RR_IDX_W-1:0];
      if (!found && elig[idx]) begin
        gnt   = idx;
        found = 1'b1;
      end
    end
  end

  assign any_elig   = |elig;
  assign can_accept = !out_valid || out_ready;
  assign xfer       = !rst && can_accept && any_elig;
  assign req_ready  = xfer ? (4'b0001 << gnt) : 4'b0000;
  assign mux_sel    = (|req_valid) ? gnt : ptr;

  Mux4to1_32b u_mux (
    .S  (mux_sel),
    .I0 (req_data0),
    .I1 (req_data1),
    .I2 (req_data2),
    .I3 (req_data3),
    .Y  (mux_y)
  );

  // A reload and a drain in the same cycle keep out_valid high for full throughput.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= PTR_RESET;
`ifdef RR_ARB4_LOCK_EN
      lock_act  <= 1'b0;
      lock_own  <= '0;
`endif
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= mux_y;
      out_src   <= gnt;
`ifdef RR_ARB4_LOCK_EN
      if (req_lock[gnt]) begin
        lock_act <= 1'b1;
        lock_own <= gnt;
      end else begin
        lock_act <= 1'b0;
        ptr      <= rr_next_idx(gnt);
      end
`else
      ptr       <= rr_next_idx(gnt);
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb4_stage.sv
// Directed scoreboard bench for rr_arb4_stage; lock sequence runs when RR_ARB4_LOCK_EN is defined.
module tb_rr_arb4_stage;
  import rr_arb4_defs::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_lock;
  logic [3:0]  req_ready;
  logic [31:0] dat [4];
  logic [1:0]  mux_sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_src;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0]  src;
    logic [31:0] data;
  } exp_t;
  exp_t expq[$];

  rr_arb4_stage #(.PTR_RESET(2'd0)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
`ifdef RR_ARB4_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_ready (req_ready),
    .req_data0 (dat[0]),
    .req_data1 (dat[1]),
    .req_data2 (dat[2]),
    .req_data3 (dat[3]),
    .mux_sel   (mux_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, check the combinational handshake, queue any expected word.
  task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] lock, input logic rdy,
                               input logic [3:0] exp_ready, input logic [1:0] exp_sel);
    req_valid = valid;
    req_lock  = lock;
    out_ready = rdy;
    #1;
    checkOutput("req_ready", {28'd0, req_ready}, {28'd0, exp_ready});
    checkOutput("mux_sel", {30'd0, mux_sel}, {30'd0, exp_sel});
    for (int i = 0; i < 4; i++)
      if (exp_ready[i]) expq.push_back('{src: 2'(i), data: dat[i]});
    @(posedge clk);
    #1;
  endtask

  // Monitor: every word the consumer takes must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_word: got src=%0d data=0x%08h, expected none", out_src, out_data);
        end else begin
          e = expq.pop_front();
          checkOutput("out_src", {30'd0, out_src}, {30'd0, e.src});
          checkOutput("out_data", out_data, e.data);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_valid = 4'b0;
    req_lock  = 4'b0;
    out_ready = 1'b0;
    dat[0] = 32'hA0; dat[1] = 32'hA1; dat[2] = 32'hA2; dat[3] = 32'hA3;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_out_src", {30'd0, out_src}, 32'd0);
    applyStimulus(4'b1111, 4'b0, 1'b1, 4'b0000, 2'd0);
    rst = 1'b0;

    // Full-throughput rotation 0..3, pointer wraps back to 0.
    applyStimulus(4'b1111, 4'b0, 1'b1, 4'b0001, 2'd0);
    applyStimulus(4'b1110, 4'b0, 1'b1, 4'b0010, 2'd1);
    applyStimulus(4'b1100, 4'b0, 1'b1, 4'b0100, 2'd2);
    applyStimulus(4'b1000, 4'b0, 1'b1, 4'b1000, 2'd3);
    applyStimulus(4'b0000, 4'b0, 1'b1, 4'b0000, 2'd0);

    // Single requester into a stalled consumer.
    dat[2] = 32'hDEADBEEF;
    applyStimulus(4'b0100, 4'b0, 1'b0, 4'b0100, 2'd2);
    applyStimulus(4'b0100, 4'b0, 1'b0, 4'b0000, 2'd2);
    checkOutput("stall_out_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("stall_out_data", out_data, 32'hDEADBEEF);
    applyStimulus(4'b0100, 4'b0, 1'b0, 4'b0000, 2'd2);
    checkOutput("stall_out_data2", out_data, 32'hDEADBEEF);
    applyStimulus(4'b0000, 4'b0, 1'b1, 4'b0000, 2'd3);
    checkOutput("drain_out_valid", {31'd0, out_valid}, 32'd0);

    // Pointer at 3 with requesters 1 and 3: 3 first, then 1.
    applyStimulus(4'b1010, 4'b0, 1'b1, 4'b1000, 2'd3);
    applyStimulus(4'b0010, 4'b0, 1'b1, 4'b0010, 2'd1);

    // Reset with a word held and a transfer pending: the word is discarded.
    applyStimulus(4'b0001, 4'b0, 1'b0, 4'b0000, 2'd0);
    rst = 1'b1;
    expq.delete();
    applyStimulus(4'b0001, 4'b0, 1'b0, 4'b0000, 2'd0);
    rst = 1'b0;
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_out_data", out_data, 32'd0);
    applyStimulus(4'b0000, 4'b0, 1'b1, 4'b0000, 2'd0);

`ifdef RR_ARB4_LOCK_EN
    // Requester 1 holds ownership for three words while 0 and 2 wait.
    dat[0] = 32'h1000_0000; dat[2] = 32'h2000_0000;
    applyStimulus(4'b0001, 4'b0000, 1'b1, 4'b0001, 2'd0);
    dat[1] = 32'h1111_0001;
    applyStimulus(4'b0111, 4'b0010, 1'b1, 4'b0010, 2'd1);
    applyStimulus(4'b0101, 4'b0000, 1'b1, 4'b0000, 2'd1);
    dat[1] = 32'h1111_0002;
    applyStimulus(4'b0111, 4'b0010, 1'b1, 4'b0010, 2'd1);
    dat[1] = 32'h1111_0003;
    applyStimulus(4'b0111, 4'b0000, 1'b1, 4'b0010, 2'd1);
    applyStimulus(4'b0101, 4'b0000, 1'b1, 4'b0100, 2'd2);
    applyStimulus(4'b0001, 4'b0000, 1'b1, 4'b0001, 2'd0);
`endif

    applyStimulus(4'b0000, 4'b0, 1'b1, 4'b0000, mux_sel_idle());
    applyStimulus(4'b0000, 4'b0, 1'b1, 4'b0000, mux_sel_idle());
    checkOutput("scoreboard_empty", expq.size(), 32'd0);
    checkOutput("final_out_valid", {31'd0, out_valid}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Idle pointer position at the end of the run depends on whether the lock sequence ran.
  function automatic logic [1:0] mux_sel_idle();
`ifdef RR_ARB4_LOCK_EN
    return 2'd1;
`else
    return 2'd0;
`endif
  endfunction

endmodule
